lii_credit_egress: RTL

- Output-port stage placed directly downstream of each router output port. It consumes one LII stream (ready/valid, per-beat sideband) and drives a registered, credit-flow-controlled link toward a remote receiver that has CREDITS beat buffers.
- It tracks packet boundaries, counts completed packets, and provides a graceful flush: stop at a packet boundary, then wait for all credits to return. The flush is used before partial reconfiguration of the downstream region.

---
 rtl/lii_pkg.sv | 37 +++
 rtl/lii_credit_counter.sv | 53 +++++
 rtl/lii_credit_egress.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lii_pkg.sv
// Shared types, widths and helpers for the LII credit egress slice.
// Imported by the credit counter and the egress top.
package lii_pkg;

    localparam int LII_DW     = 256;
    localparam int LII_KW     = LII_DW / 8;
    localparam int LII_SRC_W  = 8;
    localparam int LII_DST_W  = 8;
    localparam int LII_TYPE_W = 2;

    localparam int TW = LII_DW + 2 * LII_KW + 1
                      + LII_SRC_W + LII_DST_W + LII_TYPE_W;

    typedef enum logic [1:0] {
        LII_REQ = 2'd0,
        LII_RSP = 2'd1,
        LII_EVT = 2'd2,
        LII_CFG = 2'd3
    } lii_type_e;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_STOP_PEND = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_STOPPED   = 2'd3
    } egr_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v)
                r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/lii_credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
// full_nxt reports whether the counter will be full after this cycle.
module lii_credit_counter
    import lii_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int CW      = clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          ovf,
    output logic          full_nxt
);

    localparam logic [CW-1:0] MAX = CW'(CREDITS);

    logic [CW-1:0] cnt_nxt;
    logic          ovf_set;

    // next count: take/return cancel, return at full saturates
    always_comb begin
        cnt_nxt = cnt;
        ovf_set = 1'b0;
        unique case (1'b1)
            inc && !dec: begin
                if (cnt == MAX)
                    ovf_set = 1'b1;
                else
                    cnt_nxt = cnt + 1'b1;
            end
            dec && !inc: cnt_nxt = cnt - 1'b1;
            default: ;
        endcase
    end

    assign full_nxt = (cnt_nxt == MAX);

    // count and sticky overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= MAX;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (ovf_set)
                ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/lii_credit_egress.sv
// Credit-flow-controlled egress stage: LII stream in, registered link out,
// packet tracking and a graceful flush that stops at a packet boundary.
module lii_credit_egress
    import lii_pkg::*;
#(
    parameter int DW      = 256,
    parameter int SRC_W   = 8,
    parameter int DST_W   = 8,
    parameter int TYPE_W  = 2,
    parameter int CREDITS = 4,
    parameter int CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DW-1:0]                  s_data,
    input  logic [DW/8-1:0]                s_keep,
    input  logic [DW/8-1:0]                s_strb,
    input  logic                           s_last,
    input  logic [SRC_W-1:0]               s_src,
    input  logic [DST_W-1:0]               s_dst,
    input  logic [TYPE_W-1:0]              s_type,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic [DW-1:0]                  l_data,
    output logic [DW/8-1:0]                l_keep,
    output logic [DW/8-1:0]                l_strb,
    output logic                           l_last,
    output logic [SRC_W-1:0]               l_src,
    output logic [DST_W-1:0]               l_dst,
    output logic [TYPE_W-1:0]              l_type,
    output logic                           l_valid,
    input  logic                           l_credit,
    input  logic                           flush_req,
    output logic                           flush_done,
    output logic [clog2(CREDITS+1)-1:0]    credit_cnt,
    output logic                           in_pkt,
    output logic [CNT_W-1:0]               pkt_cnt,
    output logic                           err_credit_ovf
);

    localparam int CW = clog2(CREDITS + 1);

    egr_state_e state, state_nxt;
    logic       accept_en;
    logic       acc;
    logic       in_pkt_nxt;
    logic       full_nxt;

    assign s_ready    = (credit_cnt != '0) & accept_en;
    assign acc        = s_valid & s_ready;
    assign in_pkt_nxt = acc ? ~s_last : in_pkt;

    lii_credit_counter #(
        .CREDITS (CREDITS),
        .CW      (CW)
    ) u_credit (
        .clk      (clk),
        .rst      (rst),
        .dec      (acc),
        .inc      (l_credit),
        .cnt      (credit_cnt),
        .ovf      (err_credit_ovf),
        .full_nxt (full_nxt)
    );

    // flush FSM: next state and acceptance enable
    always_comb begin
        state_nxt = state;
        accept_en = 1'b0;
        unique case (state)
            ST_RUN: begin
                accept_en = 1'b1;
                if (flush_req)
                    state_nxt = in_pkt_nxt ? ST_STOP_PEND : ST_DRAIN;
            end
            ST_STOP_PEND: begin
                accept_en = in_pkt;
                if (!in_pkt_nxt)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (full_nxt)
                    state_nxt = ST_STOPPED;
            end
            ST_STOPPED: begin
                if (!flush_req)
                    state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // state register; flush_done is high exactly while STOPPED
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_done <= (state_nxt == ST_STOPPED);
        end
    end

    // packet boundary tracking and completed-packet count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_pkt  <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            in_pkt <= in_pkt_nxt;
            if (acc && s_last)
                pkt_cnt <= pkt_cnt + 1'b1;
        end
    end

    // link register: one l_valid pulse per accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_valid <= 1'b0;
            l_data  <= '0;
            l_keep  <= '0;
            l_strb  <= '0;
            l_last  <= 1'b0;
            l_src   <= '0;
            l_dst   <= '0;
            l_type  <= '0;
        end else begin
            l_valid <= acc;
            if (acc) begin
                l_data <= s_data;
                l_keep <= s_keep;
                l_strb <= s_strb;
                l_last <= s_last;
                l_src  <= s_src;
                l_dst  <= s_dst;
                l_type <= s_type;
            end
        end
    end

endmodule
